// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between two requesters (fetch and data), the arbiter and a registered memory.
//   fetch : i_req, i_addr -> i_ack, i_rdata, i_err
//   data  : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata, d_err
//   memory: MemRead, MemWrite, ADDR, Data_in -> Data_out
//   status: busy
//   modport slave is the arbiter side; modport master is the requester/memory side.
interface mem_arbiter_if;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        d_err;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] ADDR;
    logic [15:0] Data_in;
    logic [15:0] Data_out;
    logic        busy;
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, Data_out,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, MemRead, MemWrite, ADDR, Data_in, busy
    );
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, Data_out,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, MemRead, MemWrite, ADDR, Data_in, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto a single registered memory, one transaction in flight.
//   CLK    : system clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : mem_arbiter_if.slave (requester handshakes, memory strobes, busy)
//   MEM_WORDS : addresses >= MEM_WORDS are rejected with err=1 and never reach memory
//   ARB_RR_EN : when defined, contention alternates between ports (first contention to data);
//               when undefined, data always wins contention.
module mem_arbiter #(
    parameter int MEM_WORDS = 1024
) (
    input logic          CLK,
    input logic          resetn,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t      state, state_nxt;
    logic        owner;
    logic        we;
    logic        err;
    logic        any_req;
    logic        grant_d;
    logic        oor;
    logic [15:0] req_addr;
`ifdef ARB_RR_EN
    logic        last;
`endif
    always_comb begin
        any_req = bus.i_req | bus.d_req;
`ifdef ARB_RR_EN
        // last=0 means fetch was granted last, so data wins the next contention
        grant_d = bus.d_req & (~bus.i_req | ~last);
`else
        grant_d = bus.d_req;
`endif
        req_addr  = grant_d ? bus.d_addr : bus.i_addr;
        oor       = {16'd0, req_addr} >= 32'(MEM_WORDS);
        state_nxt = state == IDLE ? (any_req ? ISSUE : IDLE) : (state == ISSUE ? DONE : IDLE);
        bus.busy  = state != IDLE;
        bus.i_ack = state == DONE && !owner;
        bus.d_ack = state == DONE && owner;
        bus.i_err = bus.i_ack & err;
        bus.d_err = bus.d_ack & err;
        // memory registers its output, so read data is only valid during DONE
        bus.i_rdata = (bus.i_ack && !err) ? bus.Data_out : 16'd0;
        bus.d_rdata = (bus.d_ack && !err && !we) ? bus.Data_out : 16'd0;
    end
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state        <= IDLE;
            owner        <= 1'b0;
            we           <= 1'b0;
            err          <= 1'b0;
            bus.MemRead  <= 1'b0;
            bus.MemWrite <= 1'b0;
            bus.ADDR     <= 16'd0;
            bus.Data_in  <= 16'd0;
`ifdef ARB_RR_EN
            last         <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                owner        <= grant_d;
                we           <= grant_d & bus.d_we;
                err          <= oor;
                bus.MemRead  <= ~oor & ~(grant_d & bus.d_we);
                bus.MemWrite <= ~oor & grant_d & bus.d_we;
                bus.ADDR     <= req_addr;
                bus.Data_in  <= grant_d ? bus.d_wdata : 16'd0;
`ifdef ARB_RR_EN
                last         <= grant_d;
`endif
            end else begin
                bus.MemRead  <= 1'b0;
                bus.MemWrite <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue scoreboard checked by an independent ack monitor.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic resetn;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus();
    mem_arbiter #(.MEM_WORDS(1024)) dut (.CLK(CLK), .resetn(resetn), .bus(bus));

    // registered memory: output valid the cycle after MemRead is sampled
    logic [15:0] mem [0:1023];
    always @(posedge CLK) begin
        if (bus.MemWrite) mem[bus.ADDR[9:0]] <= bus.Data_in;
        if (bus.MemRead) bus.Data_out <= mem[bus.ADDR[9:0]];
    end

    typedef struct {
        logic        port;
        logic [15:0] rdata;
        logic        err;
        logic        chk_rd;
    } exp_t;
    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every ack pops one expectation
    always @(negedge CLK) begin
        if (bus.i_ack || bus.d_ack) begin
            if (q.size() == 0) chk("spurious_ack", 32'(1), 32'(0));
            else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_port", 32'({bus.i_ack, bus.d_ack}), 32'(e.port ? 2'b01 : 2'b10));
                chk("ack_err", 32'(e.port ? bus.d_err : bus.i_err), 32'(e.err));
                if (e.chk_rd) chk("ack_rdata", 32'(e.port ? bus.d_rdata : bus.i_rdata), 32'(e.rdata));
                if (e.port) chk("i_quiet", 32'({bus.i_ack, bus.i_err, bus.i_rdata}), 32'(0));
                else chk("d_quiet", 32'({bus.d_ack, bus.d_err, bus.d_rdata}), 32'(0));
            end
        end
        if (bus.MemRead || bus.MemWrite) chk("strobe_in_range", 32'(bus.ADDR < 16'd1024), 32'(1));
    end

    task automatic xact(input logic port, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rd, input logic exp_err);
        int n;
        q.push_back('{port: port, rdata: exp_rd, err: exp_err, chk_rd: !we});
        @(negedge CLK);
        if (port) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        @(negedge CLK);
        chk("issue_busy", 32'(bus.busy), 32'(1));
        chk("issue_rd", 32'(bus.MemRead), 32'(!we && !exp_err));
        chk("issue_wr", 32'(bus.MemWrite), 32'(we && !exp_err));
        if (!exp_err) chk("issue_addr", 32'(bus.ADDR), 32'(addr));
        if (we && !exp_err) chk("issue_wdata", 32'(bus.Data_in), 32'(wdata));
        // inputs changing after the grant must not disturb the transaction
        if (port) begin
            bus.d_addr = ~addr; bus.d_wdata = ~wdata;
        end else bus.i_addr = ~addr;
        n = 1;
        do begin
            @(negedge CLK);
            n++;
        end while (!(port ? bus.d_ack : bus.i_ack) && n < 8);
        chk("latency", 32'(n), 32'(2));
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    initial begin
        int n, acks, prev;
        resetn = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = 16'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'd0; bus.d_wdata = 16'd0;
        bus.Data_out = 16'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'd0;
        mem[0] = 16'h1111;
        mem[5] = 16'h02A7;
        mem[1023] = 16'hBEEF;
        repeat (3) @(negedge CLK);
        chk("rst_strobes", 32'({bus.MemRead, bus.MemWrite}), 32'(0));
        chk("rst_addr", 32'(bus.ADDR), 32'(0));
        chk("rst_data_in", 32'(bus.Data_in), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_acks", 32'({bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}), 32'(0));
        chk("rst_rdata", 32'({bus.i_rdata, bus.d_rdata}), 32'(0));
        resetn = 1'b1;

        // contention straight after reset: data wins first
`ifdef ARB_RR_EN
        for (int i = 0; i < 4; i++) q.push_back('{port: (i % 2 == 0), rdata: 16'h1111, err: 1'b0, chk_rd: 1'b1});
`else
        for (int i = 0; i < 4; i++) q.push_back('{port: 1'b1, rdata: 16'h1111, err: 1'b0, chk_rd: 1'b1});
`endif
        @(negedge CLK);
        bus.i_req = 1'b1; bus.i_addr = 16'd0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd0;
        acks = 0; prev = -1;
        for (n = 1; n <= 20 && acks < 4; n++) begin
            @(negedge CLK);
            if (bus.i_ack || bus.d_ack) begin
                chk("contention_spacing", 32'(n - prev), 32'(prev < 0 ? 3 : 3));
                prev = n;
                acks++;
            end
            if (acks == 1 && prev == n) chk("contention_first", 32'(n), 32'(2));
        end
        chk("contention_acks", 32'(acks), 32'(4));
        bus.i_req = 1'b0; bus.d_req = 1'b0;

        xact(1'b0, 1'b0, 16'd5, 16'd0, 16'h02A7, 1'b0);
        xact(1'b1, 1'b1, 16'd30, 16'd69, 16'd0, 1'b0);
        xact(1'b1, 1'b0, 16'd30, 16'd0, 16'd69, 1'b0);
        xact(1'b0, 1'b0, 16'd30, 16'd0, 16'd69, 1'b0);
        xact(1'b1, 1'b1, 16'd1024, 16'h1234, 16'd0, 1'b1);
        xact(1'b0, 1'b0, 16'd0, 16'd0, 16'h1111, 1'b0);
        xact(1'b0, 1'b0, 16'hFFFF, 16'd0, 16'd0, 1'b1);
        xact(1'b1, 1'b0, 16'd1024, 16'd0, 16'd0, 1'b1);
        xact(1'b0, 1'b0, 16'd1023, 16'd0, 16'hBEEF, 1'b0);
        xact(1'b1, 1'b1, 16'd1023, 16'hCAFE, 16'd0, 1'b0);
        xact(1'b1, 1'b0, 16'd1023, 16'd0, 16'hCAFE, 1'b0);

        // reset while ISSUE: transaction abandoned, held request re-granted after release
        @(negedge CLK);
        bus.i_req = 1'b1; bus.i_addr = 16'd5;
        @(negedge CLK);
        chk("pre_rst_busy", 32'(bus.busy), 32'(1));
        resetn = 1'b0;
        @(negedge CLK);
        chk("midrst_strobes", 32'({bus.MemRead, bus.MemWrite, bus.busy}), 32'(0));
        chk("midrst_bus", 32'({bus.ADDR, bus.Data_in}), 32'(0));
        chk("midrst_acks", 32'({bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}), 32'(0));
        resetn = 1'b1;
        q.push_back('{port: 1'b0, rdata: 16'h02A7, err: 1'b0, chk_rd: 1'b1});
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.i_ack && n < 8);
        chk("post_rst_latency", 32'(n), 32'(2));
        bus.i_req = 1'b0;

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLK);
        chk("queue_empty", 32'(q.size()), 32'(0));
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
